// File: rtl/board_tx.sv
// Serialises a 9x9 board of 2-bit cells into a byte frame: header, packed payload, XOR checksum.
// Byte handshake is valid/ready; the board is snapshotted when the frame is accepted.
module board_tx #(
    parameter logic [7:0] HEADER = 8'hA5,
    parameter int         NBYTES = 21
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [8:0][8:0][1:0]  board,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  busy,
    output logic                  done
);

    // state   | meaning
    // IDLE    | waiting for start; outputs quiet
    // HDR     | offering HEADER
    // PAYLOAD | offering packed payload byte idx_q
    // CSUM    | offering XOR of all payload bytes
    // FIN     | one-cycle done pulse, then back to IDLE
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        FIN     = 3'd4
    } state_t;

    localparam int NCELLS = 81;
    localparam int IDX_W  = $clog2(NBYTES + 1);
    localparam int FW     = NBYTES * 8;

    state_t             state_q, state_d;
    logic [FW-1:0]      snap_q;
    logic [FW-1:0]      board_packed;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         csum_q, csum_d;
    logic [7:0]         cur_byte;
    logic               load;
    logic               last_byte;

    // Cell i lands at bits [2i+1:2i], so payload byte k is simply bits [8k+7:8k];
    // bits beyond the last cell stay zero.
    always_comb begin
        board_packed = '0;
        for (int i = 0; i < NCELLS; i++) begin
            if (2 * i + 1 < FW) begin
                board_packed[2*i +: 2] = board[i / 9][i % 9];
            end
        end
    end

    always_comb begin
        cur_byte = 8'h00;
        for (int j = 0; j < NBYTES; j++) begin
            if (idx_q == IDX_W'(j)) begin
                cur_byte = snap_q[8*j +: 8];
            end
        end
    end

    assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        load     = 1'b0;
        tx_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    csum_d  = 8'h00;
                    state_d = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = HEADER;
                if (tx_ready) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = cur_byte;
                if (tx_ready) begin
                    csum_d = csum_q ^ cur_byte;
                    idx_d  = idx_q + 1'b1;
                    if (last_byte) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = csum_q;
                if (tx_ready) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            csum_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            if (load) begin
                snap_q <= board_packed;
            end
        end
    end

endmodule

// File: tb/tb_board_tx.sv
// Randomised bench for board_tx: frames are compared against a byte-list model built
// directly from the board, with stalls, mid-frame restarts and mid-frame reset.
module tb_board_tx;

    typedef logic [8:0][8:0][1:0] board_t;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        start;
    board_t      board;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];

    board_tx #(.HEADER(8'hA5), .NBYTES(21)) dut (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .start    (start),
        .board    (board),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame: header, 21 bytes of four cells each (cell i = 9*row+col), XOR checksum.
    task automatic model_frame(input board_t b);
        logic [7:0] cs;
        logic [7:0] v;
        int         i;
        exp_q = {};
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 21; k++) begin
            v = 8'h00;
            for (int j = 0; j < 4; j++) begin
                i = 4 * k + j;
                if (i < 81) v = v | (8'(b[i / 9][i % 9]) << (2 * j));
            end
            exp_q.push_back(v);
            cs = cs ^ v;
        end
        exp_q.push_back(cs);
    endtask

    function automatic board_t rand_board();
        board_t b;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                b[r][c] = 2'($urandom_range(0, 3));
        return b;
    endfunction

    function automatic board_t fill_board(input logic [1:0] code);
        board_t b;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                b[r][c] = code;
        return b;
    endfunction

    // Called and returns at posedge+1. ready_pct: chance of tx_ready per cycle.
    // restart: re-pulse start mid-frame and swap the board. rst_at: reset while frame byte rst_at offered.
    task automatic run_frame(input string name, input board_t b, input int ready_pct,
                             input bit stall5, input bit restart, input int rst_at);
        bit   hold_prev = 0;
        bit   done_seen = 0;
        bit   restarted = 0;
        int   done_cyc  = 0;
        int   stall_cnt = 0;
        logic [7:0] prev_data = 8'h00;

        model_frame(b);
        got_q = {};
        board = b;
        start = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
        chk({name, "_valid_rise"}, 32'(tx_valid), 1);
        chk({name, "_busy_rise"}, 32'(busy), 1);
        if (restart) board = rand_board();

        for (int cyc = 1; cyc <= 800; cyc++) begin
            if (rst_at >= 0 && got_q.size() == rst_at) begin
                reset_n = 1'b0;
                #1;
                chk({name, "_rst_valid"}, 32'(tx_valid), 0);
                chk({name, "_rst_busy"}, 32'(busy), 0);
                chk({name, "_rst_done"}, 32'(done), 0);
                chk({name, "_rst_data"}, 32'(tx_data), 0);
                @(negedge clk_in);
                reset_n = 1'b1;
                tx_ready = 1'b1;
                for (int n = 0; n < 5; n++) begin
                    @(negedge clk_in);
                    chk({name, "_post_rst_valid"}, 32'(tx_valid), 0);
                    chk({name, "_post_rst_busy"}, 32'(busy), 0);
                end
                @(posedge clk_in); #1;
                return;
            end
            if (stall5 && got_q.size() == 6 && stall_cnt < 10) begin
                tx_ready = 1'b0;
                stall_cnt++;
            end else begin
                tx_ready = ($urandom_range(1, 100) <= ready_pct);
            end
            if (restart && !restarted && got_q.size() == 3) begin
                start = 1'b1;
                restarted = 1;
            end
            @(negedge clk_in);
            if (hold_prev) begin
                chk({name, "_hold_valid"}, 32'(tx_valid), 1);
                chk({name, "_hold_data"}, 32'(tx_data), 32'(prev_data));
            end
            hold_prev = tx_valid && !tx_ready;
            prev_data = tx_data;
            chk({name, "_busy"}, 32'(busy), 32'(tx_valid));
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
                chk({name, "_fin_valid"}, 32'(tx_valid), 0);
                break;
            end
            @(posedge clk_in); #1;
            start = 1'b0;
        end

        if (!done_seen) begin
            chk({name, "_timeout"}, 0, 1);
        end
        if (stall5) chk({name, "_stall_len"}, 32'(stall_cnt), 10);
        if (ready_pct == 100 && !stall5 && !restart) chk({name, "_done_cycle"}, 32'(done_cyc), 24);
        chk({name, "_frame_len"}, 32'(got_q.size()), 23);
        for (int i = 0; i < got_q.size() && i < 23; i++)
            chk($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));

        @(posedge clk_in); #1;
        start = 1'b0;
        tx_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk_in);
            chk({name, "_idle_done"}, 32'(done), 0);
            chk({name, "_idle_valid"}, 32'(tx_valid), 0);
            chk({name, "_idle_busy"}, 32'(busy), 0);
        end
        @(posedge clk_in); #1;
    endtask

    initial begin
        board_t b;
        reset_n  = 1'b0;
        start    = 1'b0;
        tx_ready = 1'b0;
        board    = '0;
        #1;
        chk("reset_valid", 32'(tx_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_data", 32'(tx_data), 0);
        #20;
        reset_n = 1'b1;
        @(posedge clk_in); #1;

        run_frame("empty", fill_board(2'b00), 100, 0, 0, -1);

        b = fill_board(2'b00);
        b[0][0] = 2'b10;
        run_frame("corner00", b, 100, 0, 0, -1);

        run_frame("black", fill_board(2'b01), 100, 0, 0, -1);

        b = fill_board(2'b00);
        b[8][8] = 2'b01;
        run_frame("corner88", b, 100, 0, 0, -1);

        run_frame("stall", rand_board(), 60, 1, 0, -1);
        run_frame("restart", rand_board(), 70, 0, 1, -1);
        run_frame("reset_mid", rand_board(), 100, 0, 0, 11);
        run_frame("after_rst", rand_board(), 100, 0, 0, -1);

        for (int t = 0; t < 4; t++)
            run_frame($sformatf("rand%0d", t), rand_board(), int'($urandom_range(30, 100)), 0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
